// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode constants and jXX prediction policy selectors
package y86_pkg;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;
    localparam int PRED_ALWAYS = 0;
    localparam int PRED_BTFN   = 1;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with a saturating occupancy count
module ras_stack #(
    parameter int N         = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [N-1:0]                 din,
    output logic [N-1:0]                 top,
    output logic [$clog2(RAS_DEPTH):0]   count
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [N-1:0]  mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_up;

    assign ptr_up = ptr + 1'b1;
    assign top    = mem[ptr];

    // Pointer tracks the newest entry; a push on a full stack silently overwrites the oldest slot
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr_up;
            count <= (count == FULL) ? count : count + 1'b1;
        end else if (pop && count != '0) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Storage is not reset; only the pointer and count define what is live
    always_ff @(posedge clk) begin
        if (!reset && push) mem[ptr_up] <= din;
    end
endmodule

// File: rtl/f_pc_predict_ras.sv
// f_pc_predict_ras: Y86-64 fetch PC register with jXX prediction, RAS ret prediction and M/W repair
module f_pc_predict_ras
    import y86_pkg::*;
#(
    parameter int          N         = 64,
    parameter int          RAS_DEPTH = 8,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          PRED_MODE = PRED_ALWAYS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        f_stall,
    input  logic [3:0]                  f_icode,
    input  logic [N-1:0]                f_valP,
    input  logic [N-1:0]                f_valC,
    input  logic [3:0]                  m_icode,
    input  logic                        m_cnd,
    input  logic                        m_predtaken,
    input  logic [N-1:0]                m_valC,
    input  logic [N-1:0]                m_valA,
    input  logic [3:0]                  w_icode,
    input  logic [N-1:0]                w_valM,
    input  logic [N-1:0]                w_predPC,
    output logic [N-1:0]                f_PC,
    output logic                        f_predtaken,
    output logic                        f_ras_valid,
    output logic                        redirect,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);
    logic         m_fix;
    logic         w_fix;
    logic         upd;
    logic         push;
    logic         pop;
    logic [N-1:0] ras_top;
    logic [N-1:0] pred_pc;
    logic [N-1:0] next_pc;

    // Prediction, repair detection and next-PC selection (W is older than M, so it wins)
    always_comb begin
        m_fix       = (m_icode == ICODE_JXX) && (m_cnd != m_predtaken);
        w_fix       = (w_icode == ICODE_RET) && (w_valM != w_predPC);
        redirect    = m_fix || w_fix;
        f_predtaken = (f_icode == ICODE_JXX) && ((PRED_MODE == PRED_BTFN) ? (f_valC < f_valP) : 1'b1);
        f_ras_valid = (f_icode == ICODE_RET) && (ras_count != '0);
        pred_pc     = (f_icode == ICODE_JXX)  ? (f_predtaken ? f_valC : f_valP) :
                      (f_icode == ICODE_CALL) ? f_valC :
                      f_ras_valid             ? ras_top : f_valP;
        next_pc     = w_fix   ? w_valM :
                      m_fix   ? (m_cnd ? m_valC : m_valA) :
                      f_stall ? f_PC : pred_pc;
        upd         = !f_stall && !redirect;
        push        = upd && (f_icode == ICODE_CALL);
        pop         = upd && f_ras_valid;
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        f_PC <= reset ? RESET_PC : next_pc;
    end

    ras_stack #(.N(N), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (f_valP),
        .top   (ras_top),
        .count (ras_count)
    );
endmodule

// File: tb/tb_f_pc_predict_ras.sv
// tb_f_pc_predict_ras: randomized + directed check of two configurations against a queue-style fetch model
module tb_f_pc_predict_ras;
    logic        clk = 0;
    logic        reset, f_stall, m_cnd, m_predtaken;
    logic [3:0]  f_icode, m_icode, w_icode;
    logic [63:0] f_valP, f_valC, m_valC, m_valA, w_valM, w_predPC;

    logic [63:0] f_pc0, f_pc1;
    logic        pt0, pt1, rv0, rv1, rd0, rd1;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    logic [63:0] mpc [2];
    logic [63:0] stk [2][8];
    int          n   [2];
    int          dep [2] = '{8, 4};
    int          mode[2] = '{0, 1};

    always #5 clk = ~clk;

    f_pc_predict_ras #(.N(64), .RAS_DEPTH(8), .RESET_PC(64'h0), .PRED_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .f_stall(f_stall), .f_icode(f_icode), .f_valP(f_valP), .f_valC(f_valC),
        .m_icode(m_icode), .m_cnd(m_cnd), .m_predtaken(m_predtaken), .m_valC(m_valC), .m_valA(m_valA),
        .w_icode(w_icode), .w_valM(w_valM), .w_predPC(w_predPC),
        .f_PC(f_pc0), .f_predtaken(pt0), .f_ras_valid(rv0), .redirect(rd0), .ras_count(cnt0));

    f_pc_predict_ras #(.N(64), .RAS_DEPTH(4), .RESET_PC(64'h0), .PRED_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .f_stall(f_stall), .f_icode(f_icode), .f_valP(f_valP), .f_valC(f_valC),
        .m_icode(m_icode), .m_cnd(m_cnd), .m_predtaken(m_predtaken), .m_valC(m_valC), .m_valA(m_valA),
        .w_icode(w_icode), .w_valM(w_valM), .w_predPC(w_predPC),
        .f_PC(f_pc1), .f_predtaken(pt1), .f_ras_valid(rv1), .redirect(rd1), .ras_count(cnt1));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 0; f_stall = 0; f_icode = 4'h0; f_valP = 64'h0; f_valC = 64'h0;
        m_icode = 4'h0; m_cnd = 0; m_predtaken = 0; m_valC = 64'h0; m_valA = 64'h0;
        w_icode = 4'h0; w_valM = 64'h0; w_predPC = 64'h0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] vp, input logic [63:0] vc);
        f_icode = ic; f_valP = vp; f_valC = vc;
    endtask

    // One clock: compare outputs against the model at negedge, then advance the model at posedge
    task automatic cyc();
        bit mfix, wfix, rd, pt, rv;
        logic [63:0] top;
        @(negedge clk);
        mfix = (m_icode == 4'h7) && (m_cnd != m_predtaken);
        wfix = (w_icode == 4'h9) && (w_valM != w_predPC);
        rd   = mfix || wfix;
        for (int k = 0; k < 2; k++) begin
            pt = (f_icode == 4'h7) && (mode[k] == 0 || f_valC < f_valP);
            rv = (f_icode == 4'h9) && n[k] > 0;
            if (armed) begin
                chk($sformatf("f_PC[%0d]", k), k ? f_pc1 : f_pc0, mpc[k]);
                chk($sformatf("ras_count[%0d]", k), k ? 64'(cnt1) : 64'(cnt0), 64'(n[k]));
                chk($sformatf("f_predtaken[%0d]", k), 64'(k ? pt1 : pt0), 64'(pt));
                chk($sformatf("f_ras_valid[%0d]", k), 64'(k ? rv1 : rv0), 64'(rv));
                chk($sformatf("redirect[%0d]", k), 64'(k ? rd1 : rd0), 64'(rd));
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            pt  = (f_icode == 4'h7) && (mode[k] == 0 || f_valC < f_valP);
            top = (n[k] > 0) ? stk[k][n[k]-1] : 64'h0;
            if (reset) begin
                mpc[k] = 64'h0;
                n[k]   = 0;
            end else begin
                if (wfix)          mpc[k] = w_valM;
                else if (mfix)     mpc[k] = m_cnd ? m_valC : m_valA;
                else if (!f_stall) mpc[k] = (f_icode == 4'h7) ? (pt ? f_valC : f_valP) :
                                            (f_icode == 4'h8) ? f_valC :
                                            (f_icode == 4'h9 && n[k] > 0) ? top : f_valP;
                if (!f_stall && !rd) begin
                    if (f_icode == 4'h8) begin
                        if (n[k] == dep[k]) begin
                            for (int i = 0; i < dep[k] - 1; i++) stk[k][i] = stk[k][i+1];
                            stk[k][dep[k]-1] = f_valP;
                        end else begin
                            stk[k][n[k]] = f_valP;
                            n[k]++;
                        end
                    end else if (f_icode == 4'h9 && n[k] > 0) begin
                        n[k]--;
                    end
                end
            end
        end
        armed = 1;
        #1;
    endtask

    initial begin
        idle();
        n = '{0, 0};
        // Reset held two cycles with junk on the fetch inputs
        reset = 1;
        fetch(4'h8, 64'h1234, 64'h5678);
        cyc();
        fetch(4'h9, 64'hdead, 64'hbeef);
        cyc();
        chk("reset f_PC", f_pc0, 64'h0);
        chk("reset count", 64'(cnt0), 64'h0);
        reset = 0;
        fetch(4'h0, 64'h4, 64'h0);
        cyc();
        chk("release f_PC", f_pc0, 64'h4);

        // call then ret
        fetch(4'h8, 64'h20, 64'h100);
        cyc();
        chk("call f_PC", f_pc0, 64'h100);
        chk("call count", 64'(cnt0), 64'h1);
        fetch(4'h9, 64'h999, 64'h0);
        cyc();
        chk("ret f_PC", f_pc0, 64'h20);
        chk("ret count", 64'(cnt0), 64'h0);

        // jXX always-taken, then M mispredict while a call sits in fetch
        fetch(4'h7, 64'h50, 64'h80);
        cyc();
        chk("jxx taken f_PC", f_pc0, 64'h80);
        fetch(4'h8, 64'h88, 64'h200);
        m_icode = 4'h7; m_predtaken = 1; m_cnd = 0; m_valA = 64'h0A; m_valC = 64'h80;
        cyc();
        chk("mfix f_PC", f_pc0, 64'h0A);
        chk("mfix no push", 64'(cnt0), 64'h0);
        idle();

        // BTFN on the second instance
        fetch(4'h7, 64'h40, 64'h10);
        cyc();
        chk("btfn back taken", f_pc1, 64'h10);
        fetch(4'h7, 64'h40, 64'h90);
        cyc();
        chk("btfn fwd not taken", f_pc1, 64'h40);

        // Overflow and underflow on the depth-4 instance
        for (int i = 1; i <= 5; i++) begin
            fetch(4'h8, 64'(8 * i), 64'h1000);
            cyc();
        end
        chk("overflow count", 64'(cnt1), 64'h4);
        for (int i = 0; i < 4; i++) begin
            fetch(4'h9, 64'h777, 64'h0);
            cyc();
            chk("ret predict", f_pc1, 64'(8 * (5 - i)));
        end
        fetch(4'h9, 64'h777, 64'h0);
        cyc();
        chk("underflow f_PC", f_pc1, 64'h777);

        // Collisions: W beats M, stall holds, W fix blocks a call push
        fetch(4'h0, 64'h500, 64'h0);
        m_icode = 4'h7; m_predtaken = 1; m_cnd = 0; m_valA = 64'h0A;
        w_icode = 4'h9; w_valM = 64'h300; w_predPC = 64'h304;
        cyc();
        chk("w beats m", f_pc0, 64'h300);
        idle();
        fetch(4'h8, 64'h44, 64'h400);
        f_stall = 1;
        cyc();
        chk("stall hold f_PC", f_pc0, 64'h300);
        chk("stall hold count", 64'(cnt1), 64'h0);
        f_stall = 0;
        w_icode = 4'h9; w_valM = 64'h300; w_predPC = 64'h308;
        cyc();
        chk("wfix call f_PC", f_pc0, 64'h300);
        chk("wfix no push", 64'(cnt1), 64'h0);
        idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            reset   = ($urandom % 100) == 0;
            f_stall = ($urandom % 5) == 0;
            r = $urandom % 8;
            f_icode = (r < 3) ? 4'h7 : (r < 5) ? 4'h8 : (r < 7) ? 4'h9 : 4'($urandom % 16);
            f_valP  = {$urandom, $urandom};
            f_valC  = {$urandom, $urandom};
            m_icode = ($urandom % 4 == 0) ? 4'h7 : 4'($urandom % 16);
            m_cnd   = 1'($urandom);
            m_predtaken = 1'($urandom);
            m_valC  = {$urandom, $urandom};
            m_valA  = {$urandom, $urandom};
            w_icode = ($urandom % 4 == 0) ? 4'h9 : 4'($urandom % 16);
            w_predPC = {$urandom, $urandom};
            w_valM  = ($urandom % 2) ? w_predPC : {$urandom, $urandom};
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
